pac_wrr_arbiter: RTL and testbench
==================================

# pac_wrr_arbiter

Parametrised weighted arbiter for the Tiny_Arbiter peripheral, succeeding the single-beat round-robin core. It grants one of N requesters access to a shared sink and supports two runtime modes: weight-priority with round-robin tie-break, and weighted round robin in which the weight is a burst credit. Packet lock keeps a grant until the `last_i` beat. It also reports the number of beats remaining in the current tenure. It sits between the requester mux and the sink handshake inside the peripheral wrapper.

## Interface
- `N`, 4: number of requesters, 2..16, need not be a power of two.
- `W`, 3: weight width per requester.
- `IDX_W`, `$clog2(N)`: local parameter, index width; not overridable.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  N  per-requester request level.
- `src_valid_i`  in  1  granted source has a beat.
- `sink_ready_i`  in  1  sink accepts a beat.
- `last_i`  in  1  current beat is the last of a packet.
- `mode_i`  in  1  0 = weight-priority, 1 = weighted round robin (WRR).
- `lock_i`  in  1  1 = tenure never ends mid-packet.
- `cfg_weight_i`  in  N*W  weight k occupies bits [k*W +: W].
- `grant_o`  out  N  one-hot grant, or zero.
- `grant_idx_o`  out  IDX_W  index of the current or last winner.
- `busy_o`  out  1  FSM not IDLE.
- `credit_o`  out  W  beats remaining after the current one.
- `tenure_end_o`  out  1  pulses on the cycle a tenure ends.

## Operation
- Beat: `grant_o[curr] & src_valid_i & sink_ready_i`.
- `grant_o = (st==SERVE) ? onehot(curr_q) & req_i : 0`. This is combinational from `req_i`. It does not depend on `src_valid_i`.
- States:
  - IDLE -> PICK when `|req_i`.
  - PICK: if `|req_i`, latch the winner into `curr_q`, load `credit_q`, and go to SERVE. Otherwise go to IDLE.
  - SERVE: stays in SERVE until the tenure ends, then goes to PICK.
- Winner selection in PICK (`mode_i` is sampled only here):
  - mode 0: take the maximum weight among requesters. Ties go to the first set bit at or after `rr_ptr_q`, wrapping modulo N.
  - mode 1: take the first requester at or after `rr_ptr_q`, ignoring weight.
- Credit load: mode 0 loads 0 (one beat). Mode 1 loads `weight[winner]`, giving weight+1 beats; weight 0 still gives one beat.
- On each beat with `credit_q != 0`, `credit_q` decrements.
- Tenure ends when either:
  - `req_i[curr_q]` is 0 in SERVE, or
  - a beat occurs with `credit_q==0`, and either `lock_i==0` or `last_i==1`.
- Locked overrun: with `lock_i=1`, `credit_q` stays at 0 until a beat with `last_i=1` occurs.
- At tenure end:
  - `rr_ptr_q <= (curr_q+1)` wrapping N-1 -> 0.
  - `tenure_end_o=1` for that cycle.
- `rr_ptr_q` is never >= N.
- `grant_idx_o = curr_q` in every state.
- `credit_o = credit_q`.
- Weights and `lock_i` are live inputs. Changing a weight affects only the next PICK.

## Timing
- Reset (asynchronous, immediate) values: state IDLE, `curr_q`=0, `rr_ptr_q`=0, `credit_q`=0. Outputs: `grant_o`=0, `grant_idx_o`=0, `busy_o`=0, `credit_o`=0, `tenure_end_o`=0.
- Reset asserted mid-tenure drops the grant in the same cycle.
- Request to first grant from IDLE: 2 cycles (IDLE->PICK->SERVE).
- Back-to-back tenures: one dead PICK cycle between them.
- Withdrawing the request ends the tenure and drops the grant in the same cycle, since `grant_o` is combinational on `req_i`. A beat and a withdrawal cannot coincide.
- Beats may stall on `sink_ready_i` or `src_valid_i` indefinitely; credit is held while stalled.

## Structure
- Package `pac_arb_pkg` holds:
  - the state encoding `IDLE=0, PICK=1, SERVE=2` (2 bits);
  - the constants `MODE_PRIO=0` and `MODE_WRR=1`.
- Sub-module `pac_rr_first_one #(N)`: rotating first-one finder.
  - Inputs: mask[N] and ptr[IDX_W].
  - Outputs: idx[IDX_W] and found.
  - If the mask is empty, idx = ptr.
  - It is instantiated once, fed by the mode-selected mask: the tie mask in mode 0, `req_i` in mode 1.

## Test plan
- Mode 1, weights {3,1,0,2}, all requesting, `src_valid_i`=`sink_ready_i`=1 -> grants of 4,2,1,3 beats to requesters 0,1,2,3 in order, with one gap cycle between tenures and the sequence repeating.
- Mode 0, weights {2,5,5,1}, all requesting -> grants alternate 1,2,1,2, with `rr_ptr_q` going to 2 then 3.
- Mode 1, weight 0, `lock_i`=1 on req 0, `last_i` asserted on the 3rd beat -> req 0 holds 3 beats, `credit_o` stays 0, and `tenure_end_o` pulses on beat 3.
- Request withdrawn mid-tenure with `credit_o`=2 -> `grant_o`=0 the same cycle, `tenure_end_o`=1, PICK on the next cycle, and `rr_ptr_q=curr+1`.
- N=3, req 2 only, in a WRR tenure -> after the tenure `rr_ptr_q` wraps to 0. `sink_ready_i` held low for 5 cycles leaves `credit_o` unchanged.
- `rst_ni` pulsed low mid-SERVE -> all outputs are 0 immediately. After release with requests active, a grant appears 2 cycles later, starting at index 0 (mode 1).

Source files
------------

// File: rtl/pac_wrr_arbiter_pkg.sv
// pac_wrr_arbiter shared types.
// FSM state encoding and arbitration mode constants.
package pac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    SERVE = 2'd2
  } state_e;

  localparam logic MODE_PRIO = 1'b0;
  localparam logic MODE_WRR  = 1'b1;

endpackage

// File: rtl/pac_wrr_arbiter_if.sv
// pac_wrr_arbiter request/grant bundle.
// master drives requests and config, slave is the arbiter.
interface pac_wrr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 3
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req_i;
  logic             src_valid_i;
  logic             sink_ready_i;
  logic             last_i;
  logic             mode_i;
  logic             lock_i;
  logic [N*W-1:0]   cfg_weight_i;
  logic [N-1:0]     grant_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             busy_o;
  logic [W-1:0]     credit_o;
  logic             tenure_end_o;

  modport master (
    output req_i, src_valid_i, sink_ready_i,
    output last_i, mode_i, lock_i, cfg_weight_i,
    input  grant_o, grant_idx_o, busy_o,
    input  credit_o, tenure_end_o
  );

  modport slave (
    input  req_i, src_valid_i, sink_ready_i,
    input  last_i, mode_i, lock_i, cfg_weight_i,
    output grant_o, grant_idx_o, busy_o,
    output credit_o, tenure_end_o
  );

endinterface

// File: rtl/pac_wrr_arbiter_rr_first_one.sv
// Rotating first-one finder.
// Returns the first set bit at or after ptr_i, wrapping modulo N.
module pac_rr_first_one #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Scan offsets high to low so the smallest offset wins last.
  always_comb begin
    idx_o   = ptr_i;
    found_o = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (mask_i[jj]) begin
        idx_o   = jj;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pac_wrr_arbiter.sv
// Weighted arbiter: weight-priority or weighted round robin.
// Packet lock holds the grant until the last beat.
module pac_wrr_arbiter #(
  parameter int N = 4,
  parameter int W = 3
) (
  input logic               clk_i,
  input logic               rst_ni,
  pac_wrr_arbiter_if.slave  bus
);
  import pac_arb_pkg::*;

  localparam int IDX_W = $clog2(N);

  state_e           st_q, st_d;
  logic [IDX_W-1:0] curr_q, curr_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     credit_q, credit_d;

  logic [W-1:0]     wt [N];
  logic [W-1:0]     max_w;
  logic [N-1:0]     tie_mask;
  logic [N-1:0]     sel_mask;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] ptr_nxt;
  logic             req_cur;
  logic             beat;
  logic             tend;

  // Unpack weights, find max requesting weight and its tie set.
  always_comb begin
    max_w    = '0;
    tie_mask = '0;
    for (int k = 0; k < N; k++) begin
      wt[k] = bus.cfg_weight_i[k*W +: W];
    end
    for (int k = 0; k < N; k++) begin
      if (bus.req_i[k] && wt[k] > max_w) max_w = wt[k];
    end
    for (int k = 0; k < N; k++) begin
      tie_mask[k] = bus.req_i[k] && (wt[k] == max_w);
    end
  end

  assign sel_mask = (bus.mode_i == MODE_PRIO) ? tie_mask : bus.req_i;

  pac_rr_first_one #(.N(N)) u_ff (
    .mask_i  (sel_mask),
    .ptr_i   (ptr_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  assign req_cur = bus.req_i[curr_q];
  assign beat    = (st_q == SERVE) & req_cur
                 & bus.src_valid_i & bus.sink_ready_i;
  assign tend    = (st_q == SERVE)
                 & (~req_cur | (beat & (credit_q == '0)
                 & (~bus.lock_i | bus.last_i)));
  assign ptr_nxt = (curr_q == IDX_W'(N - 1)) ? '0 : curr_q + 1'b1;

  // Next-state: pick a winner, count down credit, end tenures.
  always_comb begin
    st_d     = st_q;
    curr_d   = curr_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    unique case (st_q)
      IDLE: begin
        if (|bus.req_i) st_d = PICK;
      end
      PICK: begin
        if (win_found) begin
          curr_d   = win_idx;
          credit_d = (bus.mode_i == MODE_WRR) ? wt[win_idx] : '0;
          st_d     = SERVE;
        end else begin
          st_d = IDLE;
        end
      end
      SERVE: begin
        if (tend) begin
          st_d  = PICK;
          ptr_d = ptr_nxt;
        end else if (beat && credit_q != '0) begin
          credit_d = credit_q - 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State and tenure registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q     <= IDLE;
      curr_q   <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      st_q     <= st_d;
      curr_q   <= curr_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign bus.grant_o      = (st_q == SERVE)
                          ? ((N'(1) << curr_q) & bus.req_i) : '0;
  assign bus.grant_idx_o  = curr_q;
  assign bus.busy_o       = (st_q != IDLE);
  assign bus.credit_o     = credit_q;
  assign bus.tenure_end_o = tend;

endmodule

// File: tb/tb_pac_wrr_arbiter.sv
// Bench for pac_wrr_arbiter: tenure-level model plus directed vectors.
// Second instance with N=3 covers pointer wrap and stall hold.
module tb_pac_wrr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pac_wrr_arbiter_if #(.N(4), .W(3)) bus4 ();
  pac_wrr_arbiter_if #(.N(3), .W(3)) bus3 ();

  pac_wrr_arbiter #(.N(4), .W(3)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4)
  );

  pac_wrr_arbiter #(.N(3), .W(3)) dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner in rotated order from ptr: WRR takes the first requester,
  // priority takes the first one with a strictly larger weight.
  function automatic int m_pick(input logic [3:0] rq, input logic md,
                                input int ptr, input logic [11:0] cw);
    int best, bw, c, w;
    best = -1;
    bw   = -1;
    for (int off = 0; off < 4; off++) begin
      c = (ptr + off) % 4;
      w = int'(cw[c*3 +: 3]);
      if (rq[c]) begin
        if (md) begin
          if (best < 0) best = c;
        end else if (w > bw) begin
          best = c;
          bw   = w;
        end
      end
    end
    return best;
  endfunction

  int         m_ph = 0;
  int         m_curr = 0;
  int         m_ptr = 0;
  int         m_cred = 0;
  logic [3:0] e_g;
  logic       e_tend;
  logic       m_beat;
  logic       m_rq;

  // Tenure-level model of the N=4 instance, compared every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ph   = 0;
      m_curr = 0;
      m_ptr  = 0;
      m_cred = 0;
    end
    m_rq   = bus4.req_i[m_curr];
    e_g    = (m_ph == 2 && m_rq) ? 4'(1 << m_curr) : 4'd0;
    m_beat = (m_ph == 2) && m_rq
           && bus4.src_valid_i && bus4.sink_ready_i;
    e_tend = (m_ph == 2) && (!m_rq || (m_beat && m_cred == 0
           && (!bus4.lock_i || bus4.last_i)));
    chk("m_grant", bus4.grant_o, e_g);
    chk("m_idx", bus4.grant_idx_o, m_curr);
    chk("m_busy", bus4.busy_o, m_ph != 0);
    chk("m_credit", bus4.credit_o, m_cred);
    chk("m_tend", bus4.tenure_end_o, e_tend);
    if (rst_n) begin
      case (m_ph)
        0: if (|bus4.req_i) m_ph = 1;
        1: begin
          if (|bus4.req_i) begin
            m_curr = m_pick(bus4.req_i, bus4.mode_i, m_ptr,
                            bus4.cfg_weight_i);
            m_cred = bus4.mode_i
                   ? int'(bus4.cfg_weight_i[m_curr*3 +: 3]) : 0;
            m_ph   = 2;
          end else begin
            m_ph = 0;
          end
        end
        default: begin
          if (e_tend) begin
            m_ptr = (m_curr + 1) % 4;
            m_ph  = 1;
          end else if (m_beat && m_cred > 0) begin
            m_cred = m_cred - 1;
          end
        end
      endcase
    end
  end

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] t1_exp [30] = '{
    4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
    4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
    4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0
  };
  logic [3:0] t2_exp [9] = '{
    4'h0, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h2, 4'h0, 4'h4
  };
  logic [3:0] t3_exp [6] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
  logic       t3_te  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    bus4.req_i = '0;
    bus4.src_valid_i = 1'b0;
    bus4.sink_ready_i = 1'b0;
    bus4.last_i = 1'b0;
    bus4.mode_i = 1'b0;
    bus4.lock_i = 1'b0;
    bus4.cfg_weight_i = '0;
    bus3.req_i = '0;
    bus3.src_valid_i = 1'b0;
    bus3.sink_ready_i = 1'b0;
    bus3.last_i = 1'b0;
    bus3.mode_i = 1'b0;
    bus3.lock_i = 1'b0;
    bus3.cfg_weight_i = '0;
    tick();
    tick();
    chk("rst_grant", bus4.grant_o, 0);
    chk("rst_busy", bus4.busy_o, 0);
    chk("rst_credit", bus4.credit_o, 0);
    rst_n = 1'b1;

    // WRR, weights {3,1,0,2}: tenures of 4,2,1,3 beats.
    bus4.cfg_weight_i = {3'd2, 3'd0, 3'd1, 3'd3};
    bus4.mode_i = 1'b1;
    bus4.src_valid_i = 1'b1;
    bus4.sink_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) bus4.req_i = 4'hF;
      @(negedge clk);
      chk("t1_grant", bus4.grant_o, t1_exp[i]);
      if (i == 5) chk("t1_tend", bus4.tenure_end_o, 1);
    end

    // Priority, weights {2,5,5,1}: tie alternates 1,2.
    tick();
    bus4.req_i = '0;
    do_reset();
    bus4.cfg_weight_i = {3'd1, 3'd5, 3'd5, 3'd2};
    bus4.mode_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) bus4.req_i = 4'hF;
      @(negedge clk);
      chk("t2_grant", bus4.grant_o, t2_exp[i]);
      if (i == 3) chk("t2_idx", bus4.grant_idx_o, 1);
      if (i == 5) chk("t2_idx", bus4.grant_idx_o, 2);
    end

    // Locked overrun: weight 0, last on beat 3.
    tick();
    bus4.req_i = '0;
    do_reset();
    bus4.cfg_weight_i = '0;
    bus4.mode_i = 1'b1;
    bus4.lock_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus4.req_i = 4'h1;
      bus4.last_i = (i == 4);
      @(negedge clk);
      chk("t3_grant", bus4.grant_o, t3_exp[i]);
      chk("t3_tend", bus4.tenure_end_o, t3_te[i]);
      chk("t3_credit", bus4.credit_o, 0);
    end
    bus4.last_i = 1'b0;
    bus4.lock_i = 1'b0;

    // Withdrawal with credit 2, then pointer moves to 1.
    tick();
    bus4.req_i = '0;
    do_reset();
    bus4.cfg_weight_i = 12'h003;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) bus4.req_i = 4'h1;
      if (i == 3) bus4.req_i = 4'h0;
      if (i == 4) bus4.req_i = 4'hF;
      @(negedge clk);
      if (i == 2) chk("t4_credit3", bus4.credit_o, 3);
      if (i == 3) begin
        chk("t4_grant", bus4.grant_o, 0);
        chk("t4_tend", bus4.tenure_end_o, 1);
        chk("t4_credit2", bus4.credit_o, 2);
      end
      if (i == 4) chk("t4_busy", bus4.busy_o, 1);
      if (i == 5) chk("t4_next", bus4.grant_o, 4'h2);
    end

    // N=3: req 2 alone, stall 5 cycles, pointer wraps to 0.
    tick();
    bus4.req_i = '0;
    do_reset();
    bus3.cfg_weight_i = {3'd2, 3'd0, 3'd0};
    bus3.mode_i = 1'b1;
    bus3.src_valid_i = 1'b1;
    bus3.sink_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) bus3.req_i = 3'b100;
      if (i == 3) bus3.sink_ready_i = 1'b0;
      if (i == 8) bus3.sink_ready_i = 1'b1;
      if (i == 10) bus3.req_i = 3'b111;
      @(negedge clk);
      if (i == 2) chk("t5_credit2", bus3.credit_o, 2);
      if (i >= 3 && i <= 7) begin
        chk("t5_stall_cr", bus3.credit_o, 1);
        chk("t5_stall_gr", bus3.grant_o, 3'b100);
      end
      if (i == 9) chk("t5_tend", bus3.tenure_end_o, 1);
      if (i == 11) chk("t5_wrap", bus3.grant_o, 3'b001);
    end
    tick();
    bus3.req_i = '0;

    // Reset mid-SERVE drops everything at once.
    do_reset();
    bus4.cfg_weight_i = {3'd2, 3'd0, 3'd1, 3'd3};
    bus4.mode_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) bus4.req_i = 4'hF;
    end
    @(negedge clk);
    chk("t6_pre", bus4.grant_o, 4'h1);
    tick();
    bus4.cfg_weight_i = {3'd2, 3'd0, 3'd3, 3'd0};
    rst_n = 1'b0;
    #1;
    chk("t6_grant", bus4.grant_o, 0);
    chk("t6_busy", bus4.busy_o, 0);
    chk("t6_credit", bus4.credit_o, 0);
    chk("t6_idx", bus4.grant_idx_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
      if (i < 2) chk("t6_gap", bus4.grant_o, 0);
      else chk("t6_first", bus4.grant_o, 4'h1);
    end

    tick();
    bus4.req_i = '0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
